scan_sel_gen: RTL

Sequential scan controller that drives the enable and 3-bit select of the 3-to-8 decoder stage directly downstream. It steps through the eight decoder outputs one at a time, holding each for a programmable dwell with a one-cycle blanking gap between steps, skips masked positions, and runs either one pass or continuously. Typical use is multiplexed display or row scanning, where the decoder's one-hot output strobes one line at a time.

---
 rtl/scan_sel_gen_pkg.sv | 13 +
 rtl/scan_next_idx.sv | 44 ++++
 rtl/scan_sel_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/scan_sel_gen_pkg.sv
// Shared encodings for the decoder scan controller: FSM states and index/mask widths.
package scan_sel_gen_pkg;

    localparam int MASK_W = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_next_idx.sv
// Combinational priority finder: next unmasked index above cur, or the lowest
// unmasked index when starting a scan or when the search has to wrap.
module scan_next_idx
    import scan_sel_gen_pkg::*;
(
    input  logic [IDX_W-1:0]  cur,
    input  logic [MASK_W-1:0] mask,
    input  logic              first,
    output logic [IDX_W-1:0]  nxt,
    output logic              wrap
);

    logic [IDX_W-1:0] lowest;
    logic [IDX_W-1:0] higher;
    logic             higher_found;

    // Downward scans so the last hit is the smallest qualifying index
    always_comb begin
        lowest       = '0;
        higher       = '0;
        higher_found = 1'b0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                lowest = IDX_W'(i);
                if (IDX_W'(i) > cur) begin
                    higher       = IDX_W'(i);
                    higher_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wrap = 1'b0;
        nxt  = lowest;
        if (!first) begin
            wrap = !higher_found;
            if (higher_found) begin
                nxt = higher;
            end
        end
    end

endmodule

// File: rtl/scan_sel_gen.sv
// Scan controller driving a 3-to-8 decoder: dwell per index, one-cycle blanking
// gap between indices, masked positions skipped, single-pass or continuous.
module scan_sel_gen
    import scan_sel_gen_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [MASK_W-1:0]  skip_mask,
    output logic               E,
    output logic [IDX_W-1:0]   sel,
    output logic               busy,
    output logic               done
);

    scan_state_t        state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] cfg_dwell, cfg_dwell_n;
    logic [MASK_W-1:0]  cfg_mask, cfg_mask_n;
    logic               cfg_mode, cfg_mode_n;
    logic               e_n, busy_n, done_n;
    logic [IDX_W-1:0]   sel_n;
    logic [IDX_W-1:0]   nxt_idx;
    logic               nxt_wrap;
    logic               in_idle;

    // In IDLE the finder looks at the live mask so the first index is ready at start
    assign in_idle = (state == IDLE);

    scan_next_idx u_next (
        .cur   (sel),
        .mask  (in_idle ? skip_mask : cfg_mask),
        .first (in_idle),
        .nxt   (nxt_idx),
        .wrap  (nxt_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cfg_dwell <= '0;
            cfg_mask  <= '0;
            cfg_mode  <= 1'b0;
            E         <= 1'b0;
            sel       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cfg_dwell <= cfg_dwell_n;
            cfg_mask  <= cfg_mask_n;
            cfg_mode  <= cfg_mode_n;
            E         <= e_n;
            sel       <= sel_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cfg_dwell_n = cfg_dwell;
        cfg_mask_n  = cfg_mask;
        cfg_mode_n  = cfg_mode;
        sel_n       = sel;
        e_n         = 1'b0;
        done_n      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !stop && (skip_mask != '1)) begin
                    cfg_dwell_n = dwell;
                    cfg_mask_n  = skip_mask;
                    cfg_mode_n  = mode;
                    sel_n       = nxt_idx;
                    cnt_n       = '0;
                    e_n         = 1'b1;
                    state_n     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (cnt == cfg_dwell) begin
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + DWELL_W'(1);
                    e_n   = 1'b1;
                end
            end
            GAP: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (nxt_wrap && cfg_mode) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    sel_n   = nxt_idx;
                    cnt_n   = '0;
                    e_n     = 1'b1;
                    state_n = ACTIVE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule
